// File: rtl/grf_writeback.sv
// ---------------------------------------------------------------------------
// grf_writeback
//   MEM/WB pipeline register and writeback-data formation for the five-stage
//   MIPS core. Captures M-stage results, aligns and extends load data, picks
//   the final GPR write value and counts retired instructions. The outputs
//   drive the register file write port and act as the W-stage forward source.
//
//   Optional build macro: GRF_WB_TRACE_EN
//     When defined, a simulation-only trace line "@pc: $rr <= data" is printed
//     for every register write that leaves W (wb_we=1, stall=0).
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   stall             hold every W-stage field
//   flush             load a bubble instead of the M-stage instruction
//   m_valid           M-stage slot holds a real instruction
//   m_pc, m_a3        M-stage PC and destination register
//   m_regwrite        instruction writes a GPR
//   m_wb_sel          0=ALU, 1=load, 2=PC+8, 3=MDU
//   m_load_type       0=lw, 1=lh, 2=lhu, 3=lb, 4=lbu (5..7 behave as lw)
//   m_alu_res         ALU result; [1:0] is the load byte offset
//   m_mem_rdata       raw data-memory word
//   m_mdu_res         HI/LO read result
//   wb_we, wb_a3      GRF write enable / address (address 0 when not writing)
//   wb_data, wb_pc    GRF write data / PC of the writing instruction
//   wb_fwd_valid      wb_data may be forwarded (same as wb_we)
//   retire_cnt        number of valid instructions that left W (wraps)
//
// Pipeline control: there is no valid/ready handshake. stall freezes the
// stage, flush inserts a bubble; priority is reset > flush > stall > capture.
// An instruction retires on the edge it leaves W: valid=1 and stall=0.
// ---------------------------------------------------------------------------
module grf_writeback #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             m_valid,
    input  logic [31:0]      m_pc,
    input  logic [4:0]       m_a3,
    input  logic             m_regwrite,
    input  logic [1:0]       m_wb_sel,
    input  logic [2:0]       m_load_type,
    input  logic [31:0]      m_alu_res,
    input  logic [31:0]      m_mem_rdata,
    input  logic [31:0]      m_mdu_res,
    output logic             wb_we,
    output logic [4:0]       wb_a3,
    output logic [31:0]      wb_data,
    output logic [31:0]      wb_pc,
    output logic             wb_fwd_valid,
    output logic [CNT_W-1:0] retire_cnt
);

    // Registered W-stage fields
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  a3;
    logic        regwrite;
    logic [1:0]  wb_sel;
    logic [2:0]  load_type;
    logic [31:0] alu_res;
    logic [31:0] mem_rdata;
    logic [31:0] mdu_res;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid     <= 1'b0;
            pc        <= RESET_PC;
            a3        <= 5'd0;
            regwrite  <= 1'b0;
            wb_sel    <= 2'd0;
            load_type <= 3'd0;
            alu_res   <= 32'd0;
            mem_rdata <= 32'd0;
            mdu_res   <= 32'd0;
        end else if (!stall) begin
            valid     <= m_valid;
            pc        <= m_pc;
            a3        <= m_a3;
            regwrite  <= m_regwrite;
            wb_sel    <= m_wb_sel;
            load_type <= m_load_type;
            alu_res   <= m_alu_res;
            mem_rdata <= m_mem_rdata;
            mdu_res   <= m_mdu_res;
        end
    end

    // The instruction currently in W is the one that retires, so the count
    // looks at the registered valid bit; a flush still lets it leave.
    always_ff @(posedge clk) begin
        if (reset) begin
            retire_cnt <= '0;
        end else if (!stall && valid) begin
            retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end

    // Load alignment and extension
    logic [1:0]  off;
    logic [15:0] half;
    logic [7:0]  byte_sel;
    logic [31:0] load_ext;

    assign off = alu_res[1:0];

    always_comb begin
        half     = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        byte_sel = mem_rdata[7:0];
        case (off)
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            2'd3:    byte_sel = mem_rdata[31:24];
            default: byte_sel = mem_rdata[7:0];
        endcase
        load_ext = mem_rdata;
        case (load_type)
            3'd1:    load_ext = {{16{half[15]}}, half};
            3'd2:    load_ext = {16'd0, half};
            3'd3:    load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'd4:    load_ext = {24'd0, byte_sel};
            default: load_ext = mem_rdata;
        endcase
    end

    // Writeback value selection
    always_comb begin
        wb_data = alu_res;
        case (wb_sel)
            2'd1:    wb_data = load_ext;
            2'd2:    wb_data = pc + 32'd8;
            2'd3:    wb_data = mdu_res;
            default: wb_data = alu_res;
        endcase
    end

    // $0 is never written, so the enable also masks a3 == 0.
    assign wb_we        = valid && regwrite && (a3 != 5'd0);
    assign wb_a3        = wb_we ? a3 : 5'd0;
    assign wb_pc        = pc;
    assign wb_fwd_valid = wb_we;

`ifdef GRF_WB_TRACE_EN
    always @(posedge clk) begin
        if (wb_we && !stall) begin
            $display("@%h: $%d <= %h", wb_pc, wb_a3, wb_data);
        end
    end
`else
`endif

endmodule

// File: tb/tb_grf_writeback.sv
module tb_grf_writeback;

    localparam int          CNT_W = 4;
    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam int          EW = 1 + 5 + 32 + 32 + CNT_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset, stall, flush;
    logic             m_valid, m_regwrite;
    logic [31:0]      m_pc, m_alu_res, m_mem_rdata, m_mdu_res;
    logic [4:0]       m_a3;
    logic [1:0]       m_wb_sel;
    logic [2:0]       m_load_type;
    logic             wb_we, wb_fwd_valid;
    logic [4:0]       wb_a3;
    logic [31:0]      wb_data, wb_pc;
    logic [CNT_W-1:0] retire_cnt;

    grf_writeback #(.RESET_PC(RST_PC), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .m_valid(m_valid), .m_pc(m_pc), .m_a3(m_a3), .m_regwrite(m_regwrite),
        .m_wb_sel(m_wb_sel), .m_load_type(m_load_type), .m_alu_res(m_alu_res),
        .m_mem_rdata(m_mem_rdata), .m_mdu_res(m_mdu_res),
        .wb_we(wb_we), .wb_a3(wb_a3), .wb_data(wb_data), .wb_pc(wb_pc),
        .wb_fwd_valid(wb_fwd_valid), .retire_cnt(retire_cnt)
    );

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    string phase   = "init";

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got %h expected %h", phase, tag, obs, exp);
        end
    endtask

    // Bench model of the W stage contents
    logic             mv, mrw;
    logic [31:0]      mpc, malu, mrd, mmdu;
    logic [4:0]       ma3;
    logic [1:0]       msel;
    logic [2:0]       mlt;
    logic [CNT_W-1:0] mcnt;

    function automatic logic [31:0] load_model(input logic [2:0] lt, input logic [31:0] rd,
                                               input logic [1:0] off);
        logic signed [31:0] t;
        logic [31:0] u;
        case (lt)
            3'd1: begin t = rd << (16 - 16 * int'(off[1])); return t >>> 16; end
            3'd2: begin u = rd << (16 - 16 * int'(off[1])); return u >> 16; end
            3'd3: begin t = rd << (24 - 8 * int'(off));     return t >>> 24; end
            3'd4: begin u = rd << (24 - 8 * int'(off));     return u >> 24; end
            default: return rd;
        endcase
    endfunction

    function automatic logic [EW-1:0] expected();
        logic        we;
        logic [31:0] d;
        we = mv && mrw && (ma3 != 5'd0);
        case (msel)
            2'd0: d = malu;
            2'd1: d = load_model(mlt, mrd, malu[1:0]);
            2'd2: d = mpc + 32'd8;
            default: d = mmdu;
        endcase
        return {we, (we ? ma3 : 5'd0), d, mpc, mcnt};
    endfunction

    task automatic model_clear();
        mv = 0; mrw = 0; ma3 = 0; mpc = RST_PC; msel = 0; mlt = 0;
        malu = 0; mrd = 0; mmdu = 0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_instr(input logic v, input logic [31:0] pc, input logic [4:0] a3,
                             input logic rw, input logic [1:0] sel, input logic [2:0] lt,
                             input logic [31:0] alu, input logic [31:0] rd,
                             input logic [31:0] mdu);
        m_valid = v; m_pc = pc; m_a3 = a3; m_regwrite = rw; m_wb_sel = sel;
        m_load_type = lt; m_alu_res = alu; m_mem_rdata = rd; m_mdu_res = mdu;
    endtask

    // One clock: apply controls, advance the model, compare after the edge.
    task automatic step(input logic rst, input logic st, input logic fl);
        logic [EW-1:0] e;
        logic          e_we;
        reset = rst; stall = st; flush = fl;
        if (rst) begin
            mcnt = '0;
            model_clear();
        end else begin
            if (!st && mv) mcnt = mcnt + 1'b1;
            if (fl) model_clear();
            else if (!st) begin
                mv = m_valid; mpc = m_pc; ma3 = m_a3; mrw = m_regwrite; msel = m_wb_sel;
                mlt = m_load_type; malu = m_alu_res; mrd = m_mem_rdata; mmdu = m_mdu_res;
            end
        end
        exp_q.push_back(expected());
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        e_we = e[EW-1];
        check("we", {31'd0, wb_we}, {31'd0, e_we});
        check("fwd", {31'd0, wb_fwd_valid}, {31'd0, e_we});
        check("a3", {27'd0, wb_a3}, {27'd0, e[EW-2 -: 5]});
        check("pc", wb_pc, e[CNT_W+31 -: 32]);
        check("cnt", {{(32-CNT_W){1'b0}}, retire_cnt}, {{(32-CNT_W){1'b0}}, e[CNT_W-1:0]});
        check("data_known", {31'd0, $isunknown(wb_data)}, 32'd0);
        if (e_we) check("data", wb_data, e[EW-7 -: 32]);
    endtask

    task automatic idle();
        set_instr(0, 32'h0, 5'd0, 0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        mcnt = '0;
        model_clear();
        idle();
        reset = 1; stall = 0; flush = 0;

        phase = "reset";
        step(1, 0, 0);
        step(1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        check("reset_cnt", {{(32-CNT_W){1'b0}}, retire_cnt}, 32'd0);

        phase = "alu";
        set_instr(1, 32'h3000, 5'd8, 1, 2'd0, 3'd0, 32'h1234, 32'h0, 32'h0);
        step(0, 0, 0);
        check("alu_data", wb_data, 32'h0000_1234);
        idle();
        step(0, 0, 0);
        check("alu_retired", {{(32-CNT_W){1'b0}}, retire_cnt}, 32'd1);

        phase = "load";
        set_instr(1, 32'h3004, 5'd9, 1, 2'd1, 3'd3, 32'h1003, 32'h8081_7F80, 32'h0);
        step(0, 0, 0); check("lb3", wb_data, 32'hFFFF_FF80);
        set_instr(1, 32'h3008, 5'd9, 1, 2'd1, 3'd4, 32'h1000, 32'h8081_7F80, 32'h0);
        step(0, 0, 0); check("lbu0", wb_data, 32'h0000_0080);
        set_instr(1, 32'h300C, 5'd9, 1, 2'd1, 3'd1, 32'h1002, 32'h8081_7F80, 32'h0);
        step(0, 0, 0); check("lh2", wb_data, 32'hFFFF_8081);
        set_instr(1, 32'h3010, 5'd9, 1, 2'd1, 3'd2, 32'h1002, 32'h8081_7F80, 32'h0);
        step(0, 0, 0); check("lhu2", wb_data, 32'h0000_8081);
        set_instr(1, 32'h3014, 5'd9, 1, 2'd1, 3'd0, 32'h1001, 32'h8081_7F80, 32'h0);
        step(0, 0, 0); check("lw", wb_data, 32'h8081_7F80);

        phase = "jal";
        set_instr(1, 32'h3010, 5'd31, 1, 2'd2, 3'd0, 32'h0, 32'h0, 32'h0);
        step(0, 0, 0); check("jal_data", wb_data, 32'h0000_3018);
        set_instr(1, 32'h3010, 5'd0, 1, 2'd2, 3'd0, 32'h0, 32'h0, 32'h0);
        step(0, 0, 0); check("jal_r0_we", {31'd0, wb_we}, 32'd0);
        set_instr(1, 32'h3020, 5'd3, 1, 2'd3, 3'd0, 32'h0, 32'h0, 32'hCAFE_0001);
        step(0, 0, 0); check("mdu_data", wb_data, 32'hCAFE_0001);

        phase = "stall";
        set_instr(1, 32'h3024, 5'd4, 1, 2'd0, 3'd0, 32'hAAAA_5555, 32'h0, 32'h0);
        step(0, 0, 0);
        set_instr(1, 32'h3028, 5'd5, 1, 2'd0, 3'd0, 32'h1111_2222, 32'h0, 32'h0);
        step(0, 1, 0);
        step(0, 1, 0);
        check("stall_hold", wb_data, 32'hAAAA_5555);
        step(0, 0, 0);
        check("stall_release", wb_data, 32'h1111_2222);

        phase = "flush";
        set_instr(1, 32'h3030, 5'd6, 1, 2'd0, 3'd0, 32'h7, 32'h0, 32'h0);
        step(0, 1, 1);
        check("flush_pc", wb_pc, RST_PC);
        idle();
        step(0, 0, 0);

        phase = "wrap";
        set_instr(1, 32'h3040, 5'd7, 1, 2'd0, 3'd0, 32'h9, 32'h0, 32'h0);
        for (int i = 0; i < 20 && mcnt != '1; i++) step(0, 0, 0);
        check("cnt_at_max", {{(32-CNT_W){1'b0}}, retire_cnt}, {{(32-CNT_W){1'b0}}, {CNT_W{1'b1}}});
        step(0, 0, 0);
        check("cnt_wrap", {{(32-CNT_W){1'b0}}, retire_cnt}, 32'd0);

        phase = "midreset";
        step(1, 0, 0);
        check("midreset_we", {31'd0, wb_we}, 32'd0);
        idle();
        step(0, 0, 0);

        phase = "random";
        for (int i = 0; i < 200; i++) begin
            set_instr(1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)),
                      1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      3'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
            step(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 7) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/grf_writeback.md
Name: grf_writeback

Overview:
- MEM/WB pipeline register plus writeback-data formation for the five-stage MIPS core.
- It is the write-side producer that drives the register file write port (A3, WE, Data, PC) and the W-stage forwarding source.
- It captures M-stage results each cycle, aligns and extends load data, selects the final writeback value, and counts retired instructions.

Parameters:
- RESET_PC, 32'h0000_3000: wb_pc value after reset and for bubbles.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high
- stall  input  1  hold W-stage register contents
- flush  input  1  replace captured instruction with bubble
- m_valid  input  1  M-stage slot holds a real instruction
- m_pc  input  32  M-stage instruction PC
- m_a3  input  5  destination register number
- m_regwrite  input  1  instruction writes a GPR
- m_wb_sel  input  2  0=ALU, 1=load, 2=PC+8, 3=MDU
- m_load_type  input  3  0=lw, 1=lh, 2=lhu, 3=lb, 4=lbu
- m_alu_res  input  32  ALU result; bits [1:0] are the load byte offset
- m_mem_rdata  input  32  raw data-memory word
- m_mdu_res  input  32  HI/LO read result
- wb_we  output  1  GRF write enable
- wb_a3  output  5  GRF write address
- wb_data  output  32  GRF write data
- wb_pc  output  32  PC of the writing instruction
- wb_fwd_valid  output  1  wb_data may be forwarded; equals wb_we
- retire_cnt  output  CNT_W  retired valid instructions

Behaviour:
- Register fields: valid, pc, a3, regwrite, wb_sel, load_type, alu_res, mem_rdata, mdu_res. All are updated on posedge clk.
- Update priority per cycle: reset > flush > stall > capture.
  - reset: valid=0, regwrite=0, a3=0, pc=RESET_PC, all data fields 0, retire_cnt=0.
  - flush: same field values as reset, except retire_cnt is kept.
  - stall (no flush): every field holds its value.
  - otherwise: every field captures its m_* input.
- Latency: one clock from M-stage inputs to wb_* outputs. wb_* are combinational from the registered fields only, never directly from m_*.
- wb_we = valid & regwrite & (a3 != 0). Writes to $0 are never issued.
- wb_a3 = a3 when wb_we, else 0. wb_pc = pc.
- wb_data selection:
  - wb_sel=0: alu_res.
  - wb_sel=2: pc + 8, modulo 2^32.
  - wb_sel=3: mdu_res.
  - wb_sel=1: load-extended data, with off = alu_res[1:0]:
    - lw: mem_rdata; off ignored.
    - lh/lhu: halfword mem_rdata[16*off[1] +: 16], sign- or zero-extended; off[0] ignored.
    - lb/lbu: byte mem_rdata[8*off +: 8], sign- or zero-extended.
    - load_type 5..7: treated as lw.
- wb_data is valid whenever wb_we=1. Its value when wb_we=0 is don't-care, but it must not be X after reset.
- retire_cnt: increments by 1 on any posedge where reset=0, stall=0, and the registered valid=1, i.e. the instruction leaving W is retired. It wraps from all-ones to 0. Flush does not clear it. A bubble never counts.
- Stall with valid=1: wb_we stays asserted on every stalled cycle. The register file rewrites the same value, which is harmless. The instruction counts once, on the cycle it leaves.
- Reset asserted mid-stream: the instruction in W is discarded in that same cycle and wb_we=0 from the next cycle.

Optional Feature:
- Macro GRF_WB_TRACE_EN.
- Defined: on each posedge with wb_we=1 and stall=0, print "@%h: $%d <= %h" using wb_pc, wb_a3, wb_data. Exactly one line per retired register write; nothing is printed for $0 or for bubbles. Simulation-only code.
- Undefined: no display code is compiled; the logic is identical.

Test Plan:
- Reset, then idle for 3 cycles -> wb_we=0, wb_pc=32'h0000_3000, retire_cnt=0.
- Capture pc=0x3000, a3=8, wb_sel=0, alu_res=0x1234 -> next cycle wb_we=1, wb_a3=8, wb_data=0x1234, wb_pc=0x3000; retire_cnt=1 one cycle later.
- Loads with mem_rdata=0x8081_7F80:
  - lb, off=3 -> 0xFFFF_FF80.
  - lbu, off=0 -> 0x0000_0080.
  - lh, off=2 -> 0xFFFF_8081.
  - lhu, off=2 -> 0x0000_8081.
  - lw -> 0x8081_7F80.
- jal-style capture: wb_sel=2, pc=0x3010, a3=31 -> wb_data=0x3018. Same instruction with a3=0 -> wb_we=0 and retire_cnt still increments.
- Stall held 2 cycles with new m_* values applied -> outputs unchanged, retire_cnt unchanged. Release stall -> count +1, new values appear.
- flush and stall asserted together with a valid m_* instruction -> bubble: wb_we=0, wb_pc=RESET_PC, retire_cnt unchanged. Preload retire_cnt to all-ones -> the next retirement wraps it to 0.
